// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int          MEM_ARB_N_REQ    = 4;
    localparam logic [31:0] MEM_ARB_ERR_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or after ptr,
// wrapping past N_REQ-1 back to 0.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N_REQ   = MEM_ARB_N_REQ,
    parameter int ID_BITS = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [ID_BITS-1:0] gnt_id,
    output logic               any
);

    // NOTE: every output gets a default before the search loop, so no path
    // through this block leaves a value held and infers a latch.
    always_comb begin
        int idx;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = ID_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Grant-on-demand round-robin arbiter sharing one native memory bus between
// N_REQ requesters. Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ          = MEM_ARB_N_REQ,
    parameter int ID_BITS        = $clog2(N_REQ),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     m_valid,
    input  logic [32*N_REQ-1:0]  m_addr,
    input  logic [32*N_REQ-1:0]  m_wdata,
    input  logic [4*N_REQ-1:0]   m_wstrb,
    output logic [N_REQ-1:0]     m_ready,
    output logic [31:0]          m_rdata,
    output logic                 s_valid,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic                 s_ready,
    input  logic [31:0]          s_rdata,
    output logic [ID_BITS-1:0]   grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_rr_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
    end

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [ID_BITS-1:0] prio_ptr;
    logic [ID_BITS-1:0] pick_id;
    logic [ID_BITS-1:0] ptr_after;
    logic               pick_any;
    logic               grant_now;
    logic               timeout_hit;

    rr_picker #(
        .N_REQ   (N_REQ),
        .ID_BITS (ID_BITS)
    ) u_picker (
        .req    (m_valid),
        .ptr    (prio_ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign grant_now = (state_q == IDLE) && pick_any;
    assign ptr_after = (pick_id == ID_BITS'(N_REQ - 1)) ? '0 : pick_id + ID_BITS'(1);

    // NOTE: non-blocking assignments in every clocked block, so each register
    // sees the pre-edge value of every other register regardless of order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = REQ;
            REQ:     if (s_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is driven from a flop, loaded from the next state so the
    // flags line up with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_ptr <= '0;
            grant_id <= '0;
            s_valid  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            m_ready  <= '0;
            m_rdata  <= '0;
            busy     <= 1'b0;
        end else begin
            s_valid <= (state_d == REQ);
            busy    <= (state_d != IDLE);
            m_ready <= (state_d == RESP) ? (N_REQ'(1) << grant_id) : '0;

            if (grant_now) begin
                grant_id <= pick_id;
                prio_ptr <= ptr_after;
                s_addr   <= m_addr[32*int'(pick_id) +: 32];
                s_wdata  <= m_wdata[32*int'(pick_id) +: 32];
                s_wstrb  <= m_wstrb[4*int'(pick_id) +: 4];
            end

            if (state_q == REQ && s_ready) begin
                m_rdata <= s_rdata;
            end else if (timeout_hit) begin
                m_rdata <= MEM_ARB_ERR_WORD;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Fires on the last permitted REQ cycle so REQ lasts exactly TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == REQ) && !s_ready &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_now) begin
                to_cnt <= '0;
            end else if (state_q == REQ && !s_ready) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: directed requests push expected
// completions; a negedge monitor pops and compares on every m_ready pulse.
`timescale 1ns/1ps
module tb_mem_rr_arbiter;
    import mem_arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic              clk;
    logic              resetn;
    logic [N-1:0]      m_valid;
    logic [32*N-1:0]   m_addr;
    logic [32*N-1:0]   m_wdata;
    logic [4*N-1:0]    m_wstrb;
    logic [N-1:0]      m_ready;
    logic [31:0]       m_rdata;
    logic              s_valid;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_ready;
    logic [31:0]       s_rdata;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              timeout_err;

    mem_rr_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   slave_delay = 0;
    int   req_cnt = 0;
    int   sready_cyc = -1;
    int   mready_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'h1234_5678 : (a ^ 32'h5A5A_A5A5);
    endfunction

    task automatic expect_txn(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rdata, input int c);
        exp_t e;
        e.id = id; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.rdata = rdata; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic issue(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        m_valid[id]           = 1'b1;
        m_addr[32*id +: 32]   = addr;
        m_wdata[32*id +: 32]  = wdata;
        m_wstrb[4*id +: 4]    = wstrb;
    endtask

    // One cycle: requesters drop on m_ready, the slave answers after slave_delay REQ cycles.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_ready[i]) m_valid[i] = 1'b0;
        end
        if (s_valid) begin
            s_ready = (req_cnt >= slave_delay);
            s_rdata = slave_word(s_addr);
            if (s_ready) sready_cyc = cyc;
            req_cnt++;
        end else begin
            s_ready = 1'b0;
            s_rdata = 32'h0;
            req_cnt = 0;
        end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((m_valid != '0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check({name, " drained"}, 32'({busy, m_valid}), 32'h0);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn  = 1'b0;
        m_valid = '0;
        s_ready = 1'b0;
        req_cnt = 0;
        sb.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: every m_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] exp_rdy;
        if (resetn && m_ready != '0) begin
            mready_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected m_ready", 32'(m_ready), 32'h0);
            end else begin
                e = sb.pop_front();
                exp_rdy = '0;
                exp_rdy[e.id] = 1'b1;
                check($sformatf("m_ready req%0d", e.id), 32'(m_ready), 32'(exp_rdy));
                check($sformatf("m_rdata req%0d", e.id), m_rdata, e.rdata);
                check($sformatf("s_addr req%0d", e.id), s_addr, e.addr);
                check($sformatf("s_wdata req%0d", e.id), s_wdata, e.wdata);
                check($sformatf("s_wstrb req%0d", e.id), 32'(s_wstrb), 32'(e.wstrb));
                if (e.cyc >= 0) check($sformatf("m_ready cycle req%0d", e.id), cyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int sv_cnt;
        int busy_low;

        resetn  = 1'b0;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 1'b0;
        s_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst s_valid", 32'(s_valid), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst m_ready", 32'(m_ready), 32'h0);
        check("rst m_rdata", m_rdata, 32'h0);
        check("rst grant_id", 32'(grant_id), 32'h0);
        check("rst s_addr", s_addr, 32'h0);
        check("rst s_wstrb", 32'(s_wstrb), 32'h0);
        check("rst timeout_err", 32'(timeout_err), 32'h0);
        resetn = 1'b1;
        tick();

        // Single read by requester 2, immediate s_ready
        slave_delay = 0;
        k = cyc;
        issue(2, 32'h0000_0010, 32'h0, 4'h0);
        expect_txn(2, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, k + 2);
        tick();
        check("t1 s_valid", 32'(s_valid), 32'h1);
        check("t1 s_wstrb", 32'(s_wstrb), 32'h0);
        check("t1 grant_id", 32'(grant_id), 32'd2);
        check("t1 busy", 32'(busy), 32'h1);
        wait_quiet("t1", 20);

        // All four contend from reset: order 0,1,2,3, three cycles apart
        do_reset();
        tick();
        k = cyc;
        for (int i = 0; i < N; i++) begin
            issue(i, 32'h0000_0400 + 32'(16 * i), 32'h0, 4'h0);
            expect_txn(i, 32'h0000_0400 + 32'(16 * i), 32'h0, 4'h0,
                       slave_word(32'h0000_0400 + 32'(16 * i)), k + 2 + 3 * i);
        end
        wait_quiet("t2", 40);
        check("t2 prio_ptr", 32'(dut.prio_ptr), 32'h0);

        // Write from requester 1; requester 3 arrives mid-REQ
        slave_delay = 3;
        k = cyc;
        issue(1, 32'h1000_0000, 32'hAABB_CCDD, 4'b0011);
        expect_txn(1, 32'h1000_0000, 32'hAABB_CCDD, 4'b0011, slave_word(32'h1000_0000), k + 5);
        tick();
        tick();
        issue(3, 32'h2000_0004, 32'h0, 4'h0);
        expect_txn(3, 32'h2000_0004, 32'h0, 4'h0, slave_word(32'h2000_0004), k + 11);
        tick();
        check("t3 s_addr mid-REQ", s_addr, 32'h1000_0000);
        check("t3 s_wdata mid-REQ", s_wdata, 32'hAABB_CCDD);
        check("t3 s_wstrb mid-REQ", 32'(s_wstrb), 32'h3);
        check("t3 grant_id mid-REQ", 32'(grant_id), 32'd1);
        wait_quiet("t3", 40);

        // Slow slave: s_valid held 5 cycles, m_ready one cycle after s_ready
        slave_delay = 4;
        k = cyc;
        issue(0, 32'h0000_0080, 32'h0, 4'h0);
        expect_txn(0, 32'h0000_0080, 32'h0, 4'h0, slave_word(32'h0000_0080), k + 6);
        sv_cnt = 0;
        busy_low = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (s_valid) begin
                sv_cnt++;
                if (!busy) busy_low++;
            end
        end
        check("t4 s_valid cycles", sv_cnt, 5);
        check("t4 busy low in REQ", busy_low, 0);
        check("t4 s_ready to m_ready", mready_cyc - sready_cyc, 1);
        wait_quiet("t4", 20);

        // Reset while in REQ
        slave_delay = 10;
        issue(1, 32'h3000_0000, 32'h5555_0000, 4'hF);
        tick();
        tick();
        check("t5 s_valid before rst", 32'(s_valid), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("t5 s_valid in rst", 32'(s_valid), 32'h0);
        check("t5 busy in rst", 32'(busy), 32'h0);
        check("t5 m_ready in rst", 32'(m_ready), 32'h0);
        check("t5 prio_ptr in rst", 32'(dut.prio_ptr), 32'h0);
        m_valid = '0;
        s_ready = 1'b0;
        req_cnt = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tick();
        slave_delay = 0;
        k = cyc;
        issue(3, 32'h0000_0C00, 32'h0, 4'h0);
        expect_txn(3, 32'h0000_0C00, 32'h0, 4'h0, slave_word(32'h0000_0C00), k + 2);
        tick();
        check("t5 grant_id after rst", 32'(grant_id), 32'd3);
        wait_quiet("t5", 20);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: slave never answers
        slave_delay = 1000;
        k = cyc;
        issue(2, 32'h0000_0044, 32'h0, 4'h0);
        expect_txn(2, 32'h0000_0044, 32'h0, 4'h0, MEM_ARB_ERR_WORD, k + 1 + TO_CYC);
        wait_quiet("t6", 40);
        check("t6 timeout_err set", 32'(timeout_err), 32'h1);
        slave_delay = 0;
        k = cyc;
        issue(0, 32'h0000_0048, 32'h0, 4'h0);
        expect_txn(0, 32'h0000_0048, 32'h0, 4'h0, slave_word(32'h0000_0048), k + 2);
        wait_quiet("t6b", 20);
        check("t6 timeout_err sticky", 32'(timeout_err), 32'h1);
        do_reset();
        tick();
        check("t6 timeout_err cleared", 32'(timeout_err), 32'h0);
`else
        // No watchdog: a long stall still completes with real data
        slave_delay = 20;
        k = cyc;
        issue(2, 32'h0000_0044, 32'h0, 4'h0);
        expect_txn(2, 32'h0000_0044, 32'h0, 4'h0, slave_word(32'h0000_0044), k + 22);
        wait_quiet("t6", 40);
        check("t6 timeout_err", 32'(timeout_err), 32'h0);
`endif

        check("scoreboard empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares one single-port memory/IO bus between `N_REQ` PicoRV32 native-interface requesters, one transaction at a time. Sits between the core array and the memory/LED/UART decode. It replaces the free-running slot counter with grant-on-demand, so an idle core costs no bus cycles. A compile-time watchdog can terminate stuck transactions.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `ID_BITS`, `$clog2(N_REQ)`, width of grant index (derived; do not override).
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles (used only with the macro).

- `clk`  in  1  system clock, all state on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `m_valid`  in  N_REQ  per-requester request; held until its `m_ready` pulse.
- `m_addr`  in  32*N_REQ  packed byte addresses, requester i at `[32*i+31 -: 32]`.
- `m_wdata`  in  32*N_REQ  packed write data.
- `m_wstrb`  in  4*N_REQ  packed byte strobes; all-zero means read.
- `m_ready`  out  N_REQ  one-hot, one-cycle completion pulse.
- `m_rdata`  out  32  read data broadcast; valid only alongside `m_ready`.
- `s_valid`  out  1  downstream request.
- `s_addr`  out  32  downstream address (registered copy of winner's).
- `s_wdata`  out  32  downstream write data.
- `s_wstrb`  out  4  downstream strobes.
- `s_ready`  in  1  downstream completion; may be high in the first `s_valid` cycle.
- `s_rdata`  in  32  downstream read data, sampled when `s_valid && s_ready`.
- `grant_id`  out  ID_BITS  index of the current or last winner.
- `busy`  out  1  high in REQ and RESP.
- `timeout_err`  out  1  sticky watchdog flag (tied 0 without the macro).

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if `|m_valid`, pick the winner with `rr_picker` and go to REQ.
  - Latch the winner's addr, wdata and wstrb into the `s_*` registers.
  - Set `grant_id` to the winner and load `prio_ptr` with `(winner+1) mod N_REQ`.
- Winner selection: the lowest index at or after `prio_ptr`, wrapping past `N_REQ-1` to 0.
- REQ: `s_valid`=1. On `s_ready`, capture `s_rdata` into `m_rdata` and go to RESP.
- RESP: `m_ready[grant_id]`=1 for exactly one cycle, then IDLE.
- Requesters follow PicoRV32 native rules: `m_valid` drops on the edge that samples `m_ready`. The IDLE cycle after RESP therefore never re-grants a finished request.
- A request arriving while busy waits. It is never dropped, and losing requesters keep their request pending.
- `m_valid` deasserting while its request is latched is a protocol violation. The latched transaction still completes.
- Reset (async, any state) sets:
  - state=IDLE, `prio_ptr`=0, `grant_id`=0.
  - `s_valid`=0; `s_addr`, `s_wdata`, `s_wstrb` = 0.
  - `m_ready`=0, `m_rdata`=0, `busy`=0, `timeout_err`=0.
  - An in-flight transaction is discarded; nothing is replayed.

## Timing
- Request seen in IDLE at cycle t gives `s_valid` at t+1.
- If `s_ready` is high at cycle u ≥ t+1, `m_ready` and `m_rdata` are valid at u+1.
- Minimum latency is 2 cycles from `m_valid` to `m_ready`. Bus throughput is one transaction per 3 cycles.
- All outputs are registered; there is no combinational path from `m_*` or `s_*` inputs to any output.
- Worst-case wait with all requesters contending is `(N_REQ-1)` transactions.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments every REQ cycle without `s_ready`.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `m_rdata`=32'hFFFF_FFFF, drop `s_valid`, and set `timeout_err`.
  - `timeout_err` is sticky and clears only on reset.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely; `timeout_err` is a constant 0.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2);
  - the default `N_REQ`;
  - the timeout read word `MEM_ARB_ERR_WORD`=32'hFFFF_FFFF.
- Sub-module `rr_picker` is purely combinational. It takes `req[N_REQ]` and `ptr[ID_BITS]` and returns `gnt_id` and `any`.

## Test plan
- Single read: requester 2 reads 0x0000_0010, `s_ready` in the first REQ cycle, `s_rdata`=0x1234_5678. Expect `m_ready`=4'b0100 two cycles after `m_valid`, `m_rdata`=0x1234_5678, `s_wstrb`=0.
- All four requesters assert together from reset. Expect grant order 0,1,2,3, each `m_ready` pulse 3 cycles apart, and `prio_ptr` back at 0.
- Requester 1 writes wstrb=4'b0011, wdata=0xAABB_CCDD to 0x1000_0000 while requester 3 arrives mid-REQ. Expect the `s_*` fields to hold the write unchanged, requester 3 granted next, and no lost request.
- `s_ready` delayed 5 cycles. Expect `s_valid` held for 5 cycles, `busy` high, and `m_ready` exactly 1 cycle after `s_ready`.
- Assert `resetn`=0 in REQ. Expect `s_valid`, `busy` and `m_ready` to go 0 immediately; after release, a fresh request from requester 3 is granted first.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, hold `s_ready` low. Expect `m_ready` with `m_rdata`=0xFFFF_FFFF after 8 REQ cycles and `timeout_err` staying 1 until reset.
